// File: rtl/rs_alu_if.sv
// -----------------------------------------------------------------------------
// rs_alu_if
// Purpose : groups the dispatch, CDB, flush and issue signals of the ALU
//           reservation station into one bundle.
// Packet  : id_packet_in / issue_packet are CTRL_W + 2*XLEN bits wide,
//           laid out as {ctrl[CTRL_W-1:0], rs1_value[XLEN-1:0], rs2_value[XLEN-1:0]}.
// Signals :
//   dispatch_en, id_packet_in, dest_rob_tag,
//   rs1_rob_tag, rs1_tag_ready, rs2_rob_tag, rs2_tag_ready  - dispatch from is_stage
//   cdb_valid, cdb_tag, cdb_value                           - result broadcast
//   squash                                                  - mispredict flush
//   issue_ready (in), issue_valid, issue_packet, issue_rob_tag (out) - ALU handshake
//   rs_full (out)                                           - stall back to is_stage
// Modports: slave  = reservation station view
//           master = environment (is_stage / CDB / ALU) view
// -----------------------------------------------------------------------------
interface rs_alu_if #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int CTRL_W = 16
) ();
    localparam int PKT_W = CTRL_W + 2 * XLEN;

    logic              dispatch_en;
    logic [PKT_W-1:0]  id_packet_in;
    logic [TAG_W-1:0]  dest_rob_tag;
    logic [TAG_W-1:0]  rs1_rob_tag;
    logic              rs1_tag_ready;
    logic [TAG_W-1:0]  rs2_rob_tag;
    logic              rs2_tag_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [XLEN-1:0]   cdb_value;
    logic              squash;
    logic              issue_ready;
    logic              issue_valid;
    logic [PKT_W-1:0]  issue_packet;
    logic [TAG_W-1:0]  issue_rob_tag;
    logic              rs_full;

    modport slave (
        input  dispatch_en, id_packet_in, dest_rob_tag,
        input  rs1_rob_tag, rs1_tag_ready, rs2_rob_tag, rs2_tag_ready,
        input  cdb_valid, cdb_tag, cdb_value, squash, issue_ready,
        output issue_valid, issue_packet, issue_rob_tag, rs_full
    );

    modport master (
        output dispatch_en, id_packet_in, dest_rob_tag,
        output rs1_rob_tag, rs1_tag_ready, rs2_rob_tag, rs2_tag_ready,
        output cdb_valid, cdb_tag, cdb_value, squash, issue_ready,
        input  issue_valid, issue_packet, issue_rob_tag, rs_full
    );
endinterface

// File: rtl/rs_alu.sv
// -----------------------------------------------------------------------------
// rs_alu
// Purpose : reservation station for the ALU. Captures dispatched packets into
//           the lowest free entry, wakes pending operands from the CDB and
//           issues one operand-complete entry per cycle over valid/ready.
// Ports   : clock  - system clock, all state on posedge
//           reset  - asynchronous active-low reset
//           rs     - rs_alu_if.slave bundle (dispatch, CDB, squash, issue, rs_full)
// Build option: RS_AGE_SELECT_EN
//           defined   -> an RS_SIZE x RS_SIZE age matrix picks the oldest ready entry
//           undefined -> the lowest-index ready entry is picked
// -----------------------------------------------------------------------------
module rs_alu #(
    parameter int RS_SIZE = 8,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5,
    parameter int CTRL_W  = 16
) (
    input  logic    clock,
    input  logic    reset,
    rs_alu_if.slave rs
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int PKT_W = CTRL_W + 2 * XLEN;

    logic [RS_SIZE-1:0] busy_q, busy_d, v1_q, v1_d, v2_q, v2_d;
    logic [PKT_W-1:0]   pkt_q  [RS_SIZE];
    logic [PKT_W-1:0]   pkt_d  [RS_SIZE];
    logic [TAG_W-1:0]   dtag_q [RS_SIZE];
    logic [TAG_W-1:0]   dtag_d [RS_SIZE];
    logic [TAG_W-1:0]   t1_q   [RS_SIZE];
    logic [TAG_W-1:0]   t1_d   [RS_SIZE];
    logic [TAG_W-1:0]   t2_q   [RS_SIZE];
    logic [TAG_W-1:0]   t2_d   [RS_SIZE];
    // hold_q pins the selection while the ALU back-pressures, so a newly
    // ready lower-index (or older) entry cannot change the presented packet.
    logic               hold_q, hold_d;
    logic [IDX_W-1:0]   hold_idx_q, hold_idx_d;

    logic [RS_SIZE-1:0] ready_s, wake1_s, wake2_s, disp_we_s, clr_s;
    logic               full_s, pick_found_s, issue_valid_s, fire_s, accept_s;
    logic [IDX_W-1:0]   free_idx_s, pick_idx_s, sel_idx_s;
    logic               dep1_s, dep2_s, cap1_s, cap2_s, disp_v1_s, disp_v2_s;
    logic [PKT_W-1:0]   disp_pkt_s;

    assign ready_s       = busy_q & v1_q & v2_q;
    assign full_s        = &busy_q;
    assign pick_found_s  = |ready_s;
    assign issue_valid_s = hold_q | pick_found_s;
    assign sel_idx_s     = hold_q ? hold_idx_q : pick_idx_s;
    assign fire_s        = issue_valid_s & rs.issue_ready;
    assign accept_s      = rs.dispatch_en & ~full_s & ~rs.squash;
    assign hold_d        = issue_valid_s & ~rs.issue_ready & ~rs.squash;
    assign hold_idx_d    = sel_idx_s;

    // Operand status at dispatch: a nonzero tag that is not yet complete may
    // still be satisfied by a broadcast in the same cycle.
    assign dep1_s    = (rs.rs1_rob_tag != {TAG_W{1'b0}}) & ~rs.rs1_tag_ready;
    assign dep2_s    = (rs.rs2_rob_tag != {TAG_W{1'b0}}) & ~rs.rs2_tag_ready;
    assign cap1_s    = dep1_s & rs.cdb_valid & (rs.cdb_tag == rs.rs1_rob_tag);
    assign cap2_s    = dep2_s & rs.cdb_valid & (rs.cdb_tag == rs.rs2_rob_tag);
    assign disp_v1_s = ~dep1_s | cap1_s;
    assign disp_v2_s = ~dep2_s | cap2_s;

    // Dispatched packet with any same-cycle CDB capture merged in.
    always_comb begin
        disp_pkt_s                  = rs.id_packet_in;
        disp_pkt_s[2*XLEN-1:XLEN]   = cap1_s ? rs.cdb_value : rs.id_packet_in[2*XLEN-1:XLEN];
        disp_pkt_s[XLEN-1:0]        = cap2_s ? rs.cdb_value : rs.id_packet_in[XLEN-1:0];
    end

    // Lowest-index free entry (scan downward so the lowest hit wins).
    always_comb begin
        free_idx_s = {IDX_W{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            free_idx_s = busy_q[i] ? free_idx_s : IDX_W'(i);
        end
    end

`ifdef RS_AGE_SELECT_EN
    // age_q[i][j] = 1 means entry i was dispatched before entry j.
    logic [RS_SIZE-1:0] age_q [RS_SIZE];
    logic [RS_SIZE-1:0] age_d [RS_SIZE];
    logic               oldest_s;

    // Oldest ready entry: ready and older than every other ready entry.
    always_comb begin
        pick_idx_s = {IDX_W{1'b0}};
        oldest_s   = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            oldest_s = ready_s[i];
            for (int j = 0; j < RS_SIZE; j++) begin
                oldest_s = oldest_s & ((j == i) | ~ready_s[j] | age_q[i][j]);
            end
            pick_idx_s = oldest_s ? IDX_W'(i) : pick_idx_s;
        end
    end

    // Age matrix next state: a new entry is younger than every busy entry.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            age_d[i] = age_q[i];
            for (int j = 0; j < RS_SIZE; j++) begin
                if (rs.squash) begin
                    age_d[i][j] = 1'b0;
                end else if (disp_we_s[i]) begin
                    age_d[i][j] = 1'b0;
                end else if (disp_we_s[j]) begin
                    age_d[i][j] = busy_q[i] & ~clr_s[i];
                end else if (clr_s[i] | clr_s[j]) begin
                    age_d[i][j] = 1'b0;
                end else begin
                    age_d[i][j] = age_q[i][j];
                end
            end
        end
    end

    // Age matrix register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RS_SIZE; i++) age_q[i] <= {RS_SIZE{1'b0}};
        end else begin
            for (int i = 0; i < RS_SIZE; i++) age_q[i] <= age_d[i];
        end
    end
`else
    // Lowest-index ready entry.
    always_comb begin
        pick_idx_s = {IDX_W{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            pick_idx_s = ready_s[i] ? IDX_W'(i) : pick_idx_s;
        end
    end
`endif

    // Issue outputs; packet and tag read as zero when nothing is presented.
    always_comb begin
        rs.issue_valid = issue_valid_s;
        rs.rs_full     = full_s;
        if (issue_valid_s) begin
            rs.issue_packet  = pkt_q[sel_idx_s];
            rs.issue_rob_tag = dtag_q[sel_idx_s];
        end else begin
            rs.issue_packet  = {PKT_W{1'b0}};
            rs.issue_rob_tag = {TAG_W{1'b0}};
        end
    end

    // Entry next state: wakeup, issue free, dispatch write, squash clear.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wake1_s[i]   = busy_q[i] & ~v1_q[i] & rs.cdb_valid &
                           (rs.cdb_tag != {TAG_W{1'b0}}) & (t1_q[i] == rs.cdb_tag);
            wake2_s[i]   = busy_q[i] & ~v2_q[i] & rs.cdb_valid &
                           (rs.cdb_tag != {TAG_W{1'b0}}) & (t2_q[i] == rs.cdb_tag);
            disp_we_s[i] = accept_s & (free_idx_s == IDX_W'(i));
            clr_s[i]     = fire_s & (sel_idx_s == IDX_W'(i));

            busy_d[i] = ~rs.squash & (disp_we_s[i] | (busy_q[i] & ~clr_s[i]));
            v1_d[i]   = disp_we_s[i] ? disp_v1_s : (v1_q[i] | wake1_s[i]);
            v2_d[i]   = disp_we_s[i] ? disp_v2_s : (v2_q[i] | wake2_s[i]);

            pkt_d[i]                = pkt_q[i];
            pkt_d[i][2*XLEN-1:XLEN] = wake1_s[i] ? rs.cdb_value : pkt_q[i][2*XLEN-1:XLEN];
            pkt_d[i][XLEN-1:0]      = wake2_s[i] ? rs.cdb_value : pkt_q[i][XLEN-1:0];
            pkt_d[i]                = disp_we_s[i] ? disp_pkt_s : pkt_d[i];

            dtag_d[i] = disp_we_s[i] ? rs.dest_rob_tag : dtag_q[i];
            t1_d[i]   = disp_we_s[i] ? rs.rs1_rob_tag  : t1_q[i];
            t2_d[i]   = disp_we_s[i] ? rs.rs2_rob_tag  : t2_q[i];
        end
    end

    // Entry and selection-hold registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q     <= {RS_SIZE{1'b0}};
            v1_q       <= {RS_SIZE{1'b0}};
            v2_q       <= {RS_SIZE{1'b0}};
            hold_q     <= 1'b0;
            hold_idx_q <= {IDX_W{1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                pkt_q[i]  <= {PKT_W{1'b0}};
                dtag_q[i] <= {TAG_W{1'b0}};
                t1_q[i]   <= {TAG_W{1'b0}};
                t2_q[i]   <= {TAG_W{1'b0}};
            end
        end else begin
            busy_q     <= busy_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                pkt_q[i]  <= pkt_d[i];
                dtag_q[i] <= dtag_d[i];
                t1_q[i]   <= t1_d[i];
                t2_q[i]   <= t2_d[i];
            end
        end
    end
endmodule

// File: tb/tb_rs_alu.sv
// -----------------------------------------------------------------------------
// tb_rs_alu
// Self-checking bench for rs_alu. A slot-level reference model (entries with
// values, tags and a dispatch sequence number) predicts the issue outputs;
// directed scenarios plus a randomized run compare the DUT against it.
// Build option RS_AGE_SELECT_EN changes the expected pick order.
// -----------------------------------------------------------------------------
module tb_rs_alu;
    localparam int RS_SIZE = 8;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 5;
    localparam int CTRL_W  = 16;
    localparam int PKT_W   = CTRL_W + 2 * XLEN;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rs_alu_if #(.XLEN(XLEN), .TAG_W(TAG_W), .CTRL_W(CTRL_W)) bus ();

    rs_alu #(.RS_SIZE(RS_SIZE), .XLEN(XLEN), .TAG_W(TAG_W), .CTRL_W(CTRL_W)) u_dut (
        .clock (clock),
        .reset (reset),
        .rs    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    bit               m_busy [RS_SIZE];
    bit               m_v1   [RS_SIZE];
    bit               m_v2   [RS_SIZE];
    logic [TAG_W-1:0] m_t1   [RS_SIZE];
    logic [TAG_W-1:0] m_t2   [RS_SIZE];
    logic [TAG_W-1:0] m_dt   [RS_SIZE];
    logic [XLEN-1:0]  m_a    [RS_SIZE];
    logic [XLEN-1:0]  m_b    [RS_SIZE];
    logic [CTRL_W-1:0] m_c   [RS_SIZE];
    int               m_seq  [RS_SIZE];
    int               seq_ctr;
    bit               m_hold;
    int               m_hold_idx;

    bit               exp_valid, exp_full;
    logic [PKT_W-1:0] exp_pkt;
    logic [TAG_W-1:0] exp_tag;
    int               exp_sel;

    task automatic model_reset();
        for (int i = 0; i < RS_SIZE; i++) begin
            m_busy[i] = 1'b0; m_v1[i] = 1'b0; m_v2[i] = 1'b0;
        end
        m_hold = 1'b0;
        m_hold_idx = 0;
        seq_ctr = 0;
    endtask

    // Expected outputs from the current model state.
    task automatic model_eval();
        exp_sel = -1;
        if (m_hold) begin
            exp_sel = m_hold_idx;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (m_busy[i] && m_v1[i] && m_v2[i]) begin
`ifdef RS_AGE_SELECT_EN
                    if (exp_sel < 0 || m_seq[i] < m_seq[exp_sel]) exp_sel = i;
`else
                    if (exp_sel < 0) exp_sel = i;
`endif
                end
            end
        end
        exp_full = 1'b1;
        for (int i = 0; i < RS_SIZE; i++) if (!m_busy[i]) exp_full = 1'b0;
        exp_valid = (exp_sel >= 0);
        if (exp_valid) begin
            exp_pkt = {m_c[exp_sel], m_a[exp_sel], m_b[exp_sel]};
            exp_tag = m_dt[exp_sel];
        end else begin
            exp_pkt = '0;
            exp_tag = '0;
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit fire;
        int sel;
        int slot;
        fire = exp_valid && bus.issue_ready;
        sel  = exp_sel;
        if (bus.squash) begin
            for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 1'b0;
            m_hold = 1'b0;
            return;
        end
        slot = -1;
        for (int i = RS_SIZE - 1; i >= 0; i--) if (!m_busy[i]) slot = i;
        if (bus.cdb_valid && bus.cdb_tag != 0) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (m_busy[i] && !m_v1[i] && m_t1[i] == bus.cdb_tag) begin
                    m_a[i] = bus.cdb_value; m_v1[i] = 1'b1;
                end
                if (m_busy[i] && !m_v2[i] && m_t2[i] == bus.cdb_tag) begin
                    m_b[i] = bus.cdb_value; m_v2[i] = 1'b1;
                end
            end
        end
        if (fire) m_busy[sel] = 1'b0;
        if (bus.dispatch_en && !exp_full && slot >= 0) begin
            m_busy[slot] = 1'b1;
            m_c[slot]  = bus.id_packet_in[PKT_W-1:2*XLEN];
            m_a[slot]  = bus.id_packet_in[2*XLEN-1:XLEN];
            m_b[slot]  = bus.id_packet_in[XLEN-1:0];
            m_dt[slot] = bus.dest_rob_tag;
            m_t1[slot] = bus.rs1_rob_tag;
            m_t2[slot] = bus.rs2_rob_tag;
            m_v1[slot] = (bus.rs1_rob_tag == 0) || bus.rs1_tag_ready;
            m_v2[slot] = (bus.rs2_rob_tag == 0) || bus.rs2_tag_ready;
            if (!m_v1[slot] && bus.cdb_valid && bus.cdb_tag == bus.rs1_rob_tag) begin
                m_a[slot] = bus.cdb_value; m_v1[slot] = 1'b1;
            end
            if (!m_v2[slot] && bus.cdb_valid && bus.cdb_tag == bus.rs2_rob_tag) begin
                m_b[slot] = bus.cdb_value; m_v2[slot] = 1'b1;
            end
            m_seq[slot] = seq_ctr;
            seq_ctr++;
        end
        m_hold     = exp_valid && !bus.issue_ready;
        m_hold_idx = sel;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.dispatch_en   = 1'b0;
        bus.id_packet_in  = '0;
        bus.dest_rob_tag  = '0;
        bus.rs1_rob_tag   = '0;
        bus.rs1_tag_ready = 1'b0;
        bus.rs2_rob_tag   = '0;
        bus.rs2_tag_ready = 1'b0;
        bus.cdb_valid     = 1'b0;
        bus.cdb_tag       = '0;
        bus.cdb_value     = '0;
        bus.squash        = 1'b0;
    endtask

    task automatic drive_disp(input logic [CTRL_W-1:0] c, input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b, input logic [TAG_W-1:0] dt,
                              input logic [TAG_W-1:0] t1, input bit r1,
                              input logic [TAG_W-1:0] t2, input bit r2);
        bus.dispatch_en   = 1'b1;
        bus.id_packet_in  = {c, a, b};
        bus.dest_rob_tag  = dt;
        bus.rs1_rob_tag   = t1;
        bus.rs1_tag_ready = r1;
        bus.rs2_rob_tag   = t2;
        bus.rs2_tag_ready = r2;
    endtask

    task automatic drive_cdb(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_value = v;
    endtask

    // One clock: model follows the edge, outputs are sampled at the negedge.
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        model_eval();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        model_eval();
        n_vec++;
        if (bus.issue_valid !== 1'b0 || bus.rs_full !== 1'b0 ||
            bus.issue_packet !== '0 || bus.issue_rob_tag !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%0b full=%0b pkt=%h tag=%0d, want all zero",
                     bus.issue_valid, bus.rs_full, bus.issue_packet, bus.issue_rob_tag);
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if (bus.issue_valid !== 1'b0 || bus.rs_full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got v=%0b full=%0b, want 0 0", bus.issue_valid, bus.rs_full);
        end
    endtask

    task automatic test_t1_no_dep();
        logic [CTRL_W-1:0] c;
        logic [XLEN-1:0] a, b;
        c = CTRL_W'($urandom); a = $urandom; b = $urandom;
        bus.issue_ready = 1'b1;
        drive_disp(c, a, b, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        idle_inputs();
        n_vec++;
        if (bus.issue_valid !== 1'b1 || bus.issue_packet !== {c, a, b} || bus.issue_rob_tag !== 5'd1) begin
            n_err++;
            $display("FAIL t1_issue: got v=%0b pkt=%h tag=%0d, want v=1 pkt=%h tag=1",
                     bus.issue_valid, bus.issue_packet, bus.issue_rob_tag, {c, a, b});
        end
        tick();
        n_vec++;
        if (bus.issue_valid !== 1'b0 || bus.issue_valid !== exp_valid) begin
            n_err++;
            $display("FAIL t1_freed: got v=%0b, want 0", bus.issue_valid);
        end
    endtask

    task automatic test_t2_cdb_wakeup();
        logic [XLEN-1:0] b;
        b = $urandom;
        bus.issue_ready = 1'b1;
        drive_disp(16'h00A2, 32'hDEAD_0000, b, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0);
        tick();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            n_vec++;
            if (bus.issue_valid !== 1'b0) begin
                n_err++;
                $display("FAIL t2_wait_c%0d: got v=%0b, want 0", k, bus.issue_valid);
            end
            tick();
        end
        drive_cdb(5'd3, 32'h0000_1234);
        tick();
        idle_inputs();
        n_vec++;
        if (bus.issue_valid !== 1'b1 || bus.issue_packet[2*XLEN-1:XLEN] !== 32'h0000_1234 ||
            bus.issue_packet[XLEN-1:0] !== b || bus.issue_rob_tag !== 5'd2) begin
            n_err++;
            $display("FAIL t2_issue: got v=%0b rs1=%h rs2=%h tag=%0d, want v=1 rs1=00001234 rs2=%h tag=2",
                     bus.issue_valid, bus.issue_packet[2*XLEN-1:XLEN], bus.issue_packet[XLEN-1:0],
                     bus.issue_rob_tag, b);
        end
        tick();
        n_vec++;
        if (bus.issue_valid !== exp_valid) begin
            n_err++;
            $display("FAIL t2_drain: got v=%0b, want %0b", bus.issue_valid, exp_valid);
        end
    endtask

    task automatic test_t3_dispatch_capture();
        bus.issue_ready = 1'b1;
        drive_disp(16'h0033, 32'h1111_2222, 32'h0, 5'd6, 5'd0, 1'b0, 5'd5, 1'b0);
        drive_cdb(5'd5, 32'h0000_BEEF);
        tick();
        idle_inputs();
        n_vec++;
        if (bus.issue_valid !== 1'b1 || bus.issue_packet[XLEN-1:0] !== 32'h0000_BEEF ||
            bus.issue_rob_tag !== 5'd6) begin
            n_err++;
            $display("FAIL t3_capture: got v=%0b rs2=%h tag=%0d, want v=1 rs2=0000beef tag=6",
                     bus.issue_valid, bus.issue_packet[XLEN-1:0], bus.issue_rob_tag);
        end
        tick();
    endtask

    task automatic test_t4_full();
        bus.issue_ready = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            drive_disp(CTRL_W'(i), $urandom, $urandom, TAG_W'(i + 1), TAG_W'(8 + i), 1'b0, 5'd0, 1'b0);
            tick();
            n_vec++;
            if (bus.rs_full !== exp_full || bus.issue_valid !== exp_valid) begin
                n_err++;
                $display("FAIL t4_fill_%0d: got full=%0b v=%0b, want full=%0b v=%0b",
                         i, bus.rs_full, bus.issue_valid, exp_full, exp_valid);
            end
        end
        n_vec++;
        if (bus.rs_full !== 1'b1) begin
            n_err++;
            $display("FAIL t4_full: got full=%0b, want 1", bus.rs_full);
        end
        drive_disp(16'h0099, 32'h9, 32'h9, 5'd20, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        idle_inputs();
        n_vec++;
        if (bus.rs_full !== 1'b1 || bus.issue_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t4_drop9: got full=%0b v=%0b, want full=1 v=0", bus.rs_full, bus.issue_valid);
        end
        bus.issue_ready = 1'b1;
        drive_cdb(5'd8, 32'hCAFE_0008);
        tick();
        idle_inputs();
        n_vec++;
        if (bus.issue_valid !== 1'b1 || bus.issue_rob_tag !== 5'd1 || bus.rs_full !== 1'b1) begin
            n_err++;
            $display("FAIL t4_wake: got v=%0b tag=%0d full=%0b, want v=1 tag=1 full=1",
                     bus.issue_valid, bus.issue_rob_tag, bus.rs_full);
        end
        // Dispatch during the issuing cycle still sees rs_full and is dropped.
        drive_disp(16'h0030, 32'h30, 32'h30, 5'd30, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        idle_inputs();
        n_vec++;
        if (bus.rs_full !== 1'b0 || bus.issue_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t4_after_issue: got full=%0b v=%0b, want full=0 v=0", bus.rs_full, bus.issue_valid);
        end
        bus.squash = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_t5_order();
        logic [TAG_W-1:0] first_tag, second_tag;
`ifdef RS_AGE_SELECT_EN
        first_tag = 5'd13; second_tag = 5'd14;
`else
        first_tag = 5'd14; second_tag = 5'd13;
`endif
        bus.issue_ready = 1'b0;
        drive_disp(16'h0011, 32'h11, 32'h11, 5'd11, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive_disp(16'h0012, 32'h12, 32'h12, 5'd12, 5'd21, 1'b0, 5'd0, 1'b0);
        tick();
        drive_disp(16'h0013, 32'h13, 32'h13, 5'd13, 5'd22, 1'b0, 5'd0, 1'b0);
        bus.issue_ready = 1'b1;
        tick();
        drive_disp(16'h0014, 32'h14, 32'h14, 5'd14, 5'd22, 1'b0, 5'd0, 1'b0);
        bus.issue_ready = 1'b0;
        tick();
        idle_inputs();
        n_vec++;
        if (bus.issue_valid !== 1'b0 || bus.rs_full !== exp_full) begin
            n_err++;
            $display("FAIL t5_pending: got v=%0b full=%0b, want v=0 full=%0b", bus.issue_valid, bus.rs_full, exp_full);
        end
        drive_cdb(5'd22, 32'h0000_0022);
        tick();
        idle_inputs();
        bus.issue_ready = 1'b1;
        n_vec++;
        if (bus.issue_valid !== 1'b1 || bus.issue_rob_tag !== first_tag || bus.issue_packet !== exp_pkt) begin
            n_err++;
            $display("FAIL t5_first: got v=%0b tag=%0d pkt=%h, want v=1 tag=%0d pkt=%h",
                     bus.issue_valid, bus.issue_rob_tag, bus.issue_packet, first_tag, exp_pkt);
        end
        tick();
        n_vec++;
        if (bus.issue_valid !== 1'b1 || bus.issue_rob_tag !== second_tag) begin
            n_err++;
            $display("FAIL t5_second: got v=%0b tag=%0d, want v=1 tag=%0d",
                     bus.issue_valid, bus.issue_rob_tag, second_tag);
        end
        tick();
        n_vec++;
        if (bus.issue_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t5_done: got v=%0b, want 0", bus.issue_valid);
        end
        bus.squash = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_t6_squash();
        bus.issue_ready = 1'b0;
        drive_disp(16'h0060, 32'h60, 32'h60, 5'd16, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        for (int i = 1; i < 5; i++) begin
            drive_disp(CTRL_W'(i), $urandom, $urandom, TAG_W'(16 + i), TAG_W'(24 + i), 1'b0, 5'd0, 1'b0);
            tick();
        end
        idle_inputs();
        drive_disp(16'h0066, 32'h66, 32'h66, 5'd26, 5'd0, 1'b0, 5'd0, 1'b0);
        bus.squash = 1'b1;
        bus.issue_ready = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if (bus.issue_valid !== 1'b0 || bus.rs_full !== 1'b0 || bus.issue_rob_tag !== '0) begin
            n_err++;
            $display("FAIL t6_squash: got v=%0b full=%0b tag=%0d, want 0 0 0",
                     bus.issue_valid, bus.rs_full, bus.issue_rob_tag);
        end
        tick();
        n_vec++;
        if (bus.issue_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t6_no_dispatch: got v=%0b, want 0", bus.issue_valid);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 800; cyc++) begin
            idle_inputs();
            if ($urandom_range(0, 9) < 6)
                drive_disp(CTRL_W'($urandom), $urandom, $urandom, TAG_W'($urandom_range(1, 31)),
                           TAG_W'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                           TAG_W'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1)
                drive_cdb(TAG_W'($urandom_range(0, 7)), $urandom);
            bus.squash      = ($urandom_range(0, 49) == 0);
            bus.issue_ready = ($urandom_range(0, 9) < 6);
            tick();
            n_vec++;
            if (bus.issue_valid !== exp_valid || bus.issue_packet !== exp_pkt ||
                bus.issue_rob_tag !== exp_tag || bus.rs_full !== exp_full) begin
                n_err++;
                $display("FAIL rand_c%0d: got v=%0b pkt=%h tag=%0d full=%0b, want v=%0b pkt=%h tag=%0d full=%0b",
                         cyc, bus.issue_valid, bus.issue_packet, bus.issue_rob_tag, bus.rs_full,
                         exp_valid, exp_pkt, exp_tag, exp_full);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_disp(CTRL_W'(i), $urandom, $urandom, TAG_W'(i + 3), 5'd0, 1'b0, 5'd0, 1'b0);
            tick();
        end
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (bus.issue_valid !== 1'b0 || bus.rs_full !== 1'b0 ||
            bus.issue_packet !== '0 || bus.issue_rob_tag !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%0b full=%0b pkt=%h tag=%0d, want all zero",
                     bus.issue_valid, bus.rs_full, bus.issue_packet, bus.issue_rob_tag);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        model_eval();
        tick();
        n_vec++;
        if (bus.issue_valid !== exp_valid || bus.rs_full !== exp_full) begin
            n_err++;
            $display("FAIL reset_mid_release: got v=%0b full=%0b, want v=%0b full=%0b",
                     bus.issue_valid, bus.rs_full, exp_valid, exp_full);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.issue_ready = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clock);
        test_reset();
        test_t1_no_dep();
        test_t2_cdb_wakeup();
        test_t3_dispatch_capture();
        test_t4_full();
        test_t5_order();
        test_t6_squash();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
